gf180mcu_fd_sc_mcu9t5v0__rn_seq: RTL and testbench
==================================================

// Module: gf180mcu_fd_sc_mcu9t5v0__rn_seq
// PURPOSE
//  Reset sequencer that drives the active-low RN pins of the dffrnq flop family.
//  Asserts all domain resets together and holds them for a fixed count.
//  Then releases the domains one at a time, synchronous to CLK, in a staggered order.
//  Sits at the top of each clock domain. It merges the sync system reset, an async external
//  reset and a software request into one clean RN[] bus.
// PARAMETERS
//  NDOM        4   number of reset domains / RN outputs (>=1)
//  HOLD_CYC    16  cycles all RN held low after last reset cause clears (>=1)
//  STAGGER     4   cycles between successive domain releases (>=1)
//  SYNC_STAGES 2   synchronizer depth for EXT_RN (>=2)
// PORTS
//  CLK     input   1     clock, all state on rising edge
//  RST     input   1     synchronous active-high reset
//  EXT_RN  input   1     async active-low external reset; synchronized internally
//  SW_REQ  input   1     single-cycle software reset request, sync to CLK
//  RN      output  NDOM  active-low domain resets; RN[0] is released first
//  READY   output  1     1 = all domains released, sequence complete
//  CAUSE   output  2     last reset cause: 01 RST, 10 EXT_RN, 11 SW_REQ, 00 none
//  VDD     input   1     supply (functional model only, no logic)
//  VSS     input   1     ground (functional model only, no logic)
// BEHAVIOUR
//  - Reset (RST=1 at edge): state=ASSERT, hold cnt=0, RN=all 0, READY=0, CAUSE=01.
//    The synchronizer is not flushed by RST.
//  - ext_lo = synchronized ~EXT_RN, registered after SYNC_STAGES flops.
//    It is preset to 0 (released) at RST.
//  - States: ASSERT -> RELEASE -> RUN. All RN bits are registered, so RN is glitch-free.
//  - ASSERT: RN=all 0, READY=0.
//    - While ext_lo=1: cnt held at 0.
//    - Otherwise cnt increments each edge.
//    - At the edge where cnt==HOLD_CYC-1: go to RELEASE, set RN[0]=1, idx=0, scnt=0.
//  - RELEASE: scnt increments each edge.
//    - At scnt==STAGGER-1: scnt=0, idx++, set RN[idx].
//    - After RN[NDOM-1] is set, STAGGER more edges pass, then go to RUN with READY=1.
//  - RUN: RN=all 1, READY=1. The state is held indefinitely.
//  - Timing, counting edge 1 as the first edge with RST=0 and ext_lo=0:
//    - RN[i] rises at edge HOLD_CYC + i*STAGGER.
//    - READY rises at edge HOLD_CYC + NDOM*STAGGER.
//  - Entry to ASSERT from any state applies at the same edge:
//    - ext_lo=1 or SW_REQ=1 clears all RN and READY and resets cnt, idx and scnt.
//    - Assertion is simultaneous on all bits, with no stagger.
//  - SW_REQ in ASSERT restarts cnt at 0 and extends the hold.
//  - CAUSE is updated on every entry to or restart of ASSERT.
//    - Priority when events coincide: RST > EXT_RN > SW_REQ.
//    - CAUSE holds its value through RELEASE and RUN.
//  - EXT_RN assertion latency: RN all 0 no later than SYNC_STAGES+1 edges after EXT_RN falls.
//  - Domains never release out of order. RN[j]=1 implies RN[i]=1 for all i<j.
//  - Counter widths are $clog2 of the max count +1. Counters saturate and never wrap.
//  - NDOM=1: RN[0] at edge HOLD_CYC, READY at edge HOLD_CYC+STAGGER.
// TESTING
//  1. Defaults, RST 3 cycles then low, EXT_RN=1:
//     RN 0000 until edge 16. Then 0001@16, 0011@20, 0111@24, 1111@28. READY@32, CAUSE=01.
//  2. In RUN, SW_REQ pulse 1 cycle:
//     next edge RN=0000, READY=0, CAUSE=11. Full resequence, RN[0] 16 edges later.
//  3. Mid-RELEASE (RN=0011), EXT_RN low 10 cycles:
//     RN=0000 within 3 edges, CAUSE=10. Hold counts only after ext_lo clears,
//     so RN[0] rises 16 edges after that.
//  4. SW_REQ at cnt=10 in ASSERT: hold restarts, RN[0] rises 16 edges after the pulse.
//  5. RST and SW_REQ in the same cycle: CAUSE=01. RST mid-RUN: RN=0000 at that edge.
//  6. Assertion checks throughout random EXT_RN/SW_REQ traffic:
//     release order monotonic; READY=1 iff RN all 1 and state RUN.

Source files
------------

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__rn_seq.sv
// Reset sequencer for dffrnq RN pins: merges RST, synchronized EXT_RN and SW_REQ,
// holds every domain in reset for HOLD_CYC cycles, then releases domains in order.
module gf180mcu_fd_sc_mcu9t5v0__rn_seq #(
    parameter int unsigned NDOM        = 4,
    parameter int unsigned HOLD_CYC    = 16,
    parameter int unsigned STAGGER     = 4,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            EXT_RN,
    input  logic            SW_REQ,
    output logic [NDOM-1:0] RN,
    output logic            READY,
    output logic [1:0]      CAUSE,
    input  logic            VDD,
    input  logic            VSS
);

    localparam int unsigned CNT_W  = $clog2(HOLD_CYC + 1);
    localparam int unsigned SCNT_W = $clog2(STAGGER + 1);
    localparam int unsigned IDX_W  = $clog2(NDOM + 1);
    localparam int unsigned SLO_W  = SYNC_STAGES - 1;

    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(HOLD_CYC - 1);
    localparam logic [SCNT_W-1:0] SCNT_LAST = SCNT_W'(STAGGER - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NDOM - 1);

    localparam logic [1:0] CAUSE_RST = 2'b01;
    localparam logic [1:0] CAUSE_EXT = 2'b10;
    localparam logic [1:0] CAUSE_SW  = 2'b11;

    typedef enum logic [1:0] {
        ST_ASSERT,
        ST_RELEASE,
        ST_RUN
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [SCNT_W-1:0]   scnt_q, scnt_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [NDOM-1:0]     rn_q, rn_d;
    logic                ready_q, ready_d;
    logic [1:0]          cause_q, cause_d;
    logic [SLO_W-1:0]    sync_lo_q;
    logic                ext_lo_q;
    logic                unused_supply;

    // Supply pins exist only for pin-compatibility with the cell library view.
    assign unused_supply = VDD ^ VSS;

    // Leading synchronizer stages are deliberately left out of RST so a pending
    // external reset survives a system reset; only the final stage is preset.
    always_ff @(posedge CLK) begin
        sync_lo_q <= SLO_W'({sync_lo_q, ~EXT_RN});
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            ext_lo_q <= 1'b0;
        end else begin
            ext_lo_q <= sync_lo_q[SLO_W-1];
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_ASSERT;
            cnt_q   <= '0;
            scnt_q  <= '0;
            idx_q   <= '0;
            rn_q    <= '0;
            ready_q <= 1'b0;
            cause_q <= CAUSE_RST;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            scnt_q  <= scnt_d;
            idx_q   <= idx_d;
            rn_q    <= rn_d;
            ready_q <= ready_d;
            cause_q <= cause_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        scnt_d  = scnt_q;
        idx_d   = idx_q;
        rn_d    = rn_q;
        ready_d = ready_q;
        cause_d = cause_q;

        if (ext_lo_q || SW_REQ) begin
            // Entry or restart of ASSERT: every domain drops on the same edge.
            state_d = ST_ASSERT;
            cnt_d   = '0;
            scnt_d  = '0;
            idx_d   = '0;
            rn_d    = '0;
            ready_d = 1'b0;
            cause_d = ext_lo_q ? CAUSE_EXT : CAUSE_SW;
        end else begin
            unique case (state_q)
                ST_ASSERT: begin
                    rn_d    = '0;
                    ready_d = 1'b0;
                    if (cnt_q == CNT_LAST) begin
                        state_d = ST_RELEASE;
                        rn_d    = NDOM'(1);
                        idx_d   = '0;
                        scnt_d  = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_RELEASE: begin
                    ready_d = 1'b0;
                    if (scnt_q == SCNT_LAST) begin
                        scnt_d = '0;
                        if (idx_q == IDX_LAST) begin
                            state_d = ST_RUN;
                            rn_d    = '1;
                            ready_d = 1'b1;
                        end else begin
                            idx_d = idx_q + 1'b1;
                            rn_d  = rn_q | (NDOM'(1) << idx_d);
                        end
                    end else begin
                        scnt_d = scnt_q + 1'b1;
                    end
                end
                ST_RUN: begin
                    rn_d    = '1;
                    ready_d = 1'b1;
                end
                default: begin
                    state_d = ST_ASSERT;
                    rn_d    = '0;
                    ready_d = 1'b0;
                end
            endcase
        end
    end

    assign RN    = rn_q;
    assign READY = ready_q;
    assign CAUSE = cause_q;

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu9t5v0__rn_seq.sv
// Scoreboard bench for the RN reset sequencer: stimulus pushes expected output
// transitions, monitors pop them whenever RN/READY/CAUSE change.
module tb_gf180mcu_fd_sc_mcu9t5v0__rn_seq;

    logic       CLK = 1'b0;
    logic       RST;
    logic       EXT_RN;
    logic       SW_REQ;
    logic       VDD = 1'b1;
    logic       VSS = 1'b0;
    logic [3:0] RN;
    logic       READY;
    logic [1:0] CAUSE;
    logic [0:0] RN1;
    logic       READY1;
    logic [1:0] CAUSE1;

    gf180mcu_fd_sc_mcu9t5v0__rn_seq #(
        .NDOM(4), .HOLD_CYC(16), .STAGGER(4), .SYNC_STAGES(2)
    ) dut (
        .CLK(CLK), .RST(RST), .EXT_RN(EXT_RN), .SW_REQ(SW_REQ),
        .RN(RN), .READY(READY), .CAUSE(CAUSE), .VDD(VDD), .VSS(VSS)
    );

    gf180mcu_fd_sc_mcu9t5v0__rn_seq #(
        .NDOM(1), .HOLD_CYC(2), .STAGGER(3), .SYNC_STAGES(2)
    ) dut1 (
        .CLK(CLK), .RST(RST), .EXT_RN(EXT_RN), .SW_REQ(SW_REQ),
        .RN(RN1), .READY(READY1), .CAUSE(CAUSE1), .VDD(VDD), .VSS(VSS)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc++;

    typedef struct {
        int         c;
        logic [3:0] rn;
        logic       rdy;
        logic [1:0] cause;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   checks = 0;
    int   errors = 0;
    bit   mon0_en = 1'b0;
    bit   mon1_en = 1'b0;

    // Monitor for the 4-domain instance.
    logic [6:0] prev0;
    bit         have0 = 1'b0;
    always @(negedge CLK) begin
        exp_t e;
        if (!mon0_en) begin
            have0 = 1'b0;
        end else if (!have0 || {RN, READY, CAUSE} != prev0) begin
            have0 = 1'b1;
            prev0 = {RN, READY, CAUSE};
            checks++;
            if (q0.size() == 0) begin
                errors++;
                $display("FAIL dom4_unexpected cyc=%0d RN=%b READY=%b CAUSE=%b", cyc, RN, READY, CAUSE);
            end else begin
                e = q0.pop_front();
                if (e.c != cyc || e.rn !== RN || e.rdy !== READY || e.cause !== CAUSE) begin
                    errors++;
                    $display("FAIL dom4_event got cyc=%0d RN=%b READY=%b CAUSE=%b want cyc=%0d RN=%b READY=%b CAUSE=%b",
                             cyc, RN, READY, CAUSE, e.c, e.rn, e.rdy, e.cause);
                end
            end
        end
    end

    // Monitor for the single-domain instance.
    logic [3:0] prev1;
    bit         have1 = 1'b0;
    always @(negedge CLK) begin
        exp_t e;
        if (!mon1_en) begin
            have1 = 1'b0;
        end else if (!have1 || {RN1, READY1, CAUSE1} != prev1) begin
            have1 = 1'b1;
            prev1 = {RN1, READY1, CAUSE1};
            checks++;
            if (q1.size() == 0) begin
                errors++;
                $display("FAIL dom1_unexpected cyc=%0d RN=%b READY=%b CAUSE=%b", cyc, RN1, READY1, CAUSE1);
            end else begin
                e = q1.pop_front();
                if (e.c != cyc || e.rn[0] !== RN1[0] || e.rdy !== READY1 || e.cause !== CAUSE1) begin
                    errors++;
                    $display("FAIL dom1_event got cyc=%0d RN=%b READY=%b CAUSE=%b want cyc=%0d RN=%b READY=%b CAUSE=%b",
                             cyc, RN1, READY1, CAUSE1, e.c, e.rn[0], e.rdy, e.cause);
                end
            end
        end
    end

    // Invariants checked on every cycle once out of the initial reset.
    always @(negedge CLK) begin
        logic [3:0] rn_inc;
        if (cyc >= 3) begin
            rn_inc = RN + 4'd1;
            checks++;
            if ((RN & rn_inc) != 4'd0) begin
                errors++;
                $display("FAIL release_order cyc=%0d RN=%b want thermometer code", cyc, RN);
            end
            checks++;
            if (READY && RN != 4'hF) begin
                errors++;
                $display("FAIL ready_vs_rn cyc=%0d READY=%b RN=%b want RN=1111 when READY", cyc, READY, RN);
            end
            checks++;
            if (READY1 && !RN1[0]) begin
                errors++;
                $display("FAIL ready1_vs_rn1 cyc=%0d READY=%b RN=%b", cyc, READY1, RN1);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic step_to(input int c);
        while (cyc < c) step(1);
    endtask

    task automatic push0(input int c, input logic [3:0] rn, input logic rdy, input logic [1:0] ca);
        exp_t e;
        e.c = c; e.rn = rn; e.rdy = rdy; e.cause = ca;
        q0.push_back(e);
    endtask

    task automatic push1(input int c, input logic rn, input logic rdy, input logic [1:0] ca);
        exp_t e;
        e.c = c; e.rn = {3'b000, rn}; e.rdy = rdy; e.cause = ca;
        q1.push_back(e);
    endtask

    // Release timeline for the 4-domain instance relative to the edge where the hold count starts at 0.
    task automatic push_rel(input int base, input logic [1:0] ca, input int n);
        int         off [5] = '{16, 20, 24, 28, 32};
        logic [3:0] rv  [5] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1111};
        logic       rd  [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < n; i++) push0(base + off[i], rv[i], rd[i], ca);
    endtask

    task automatic drain0(input string name);
        checks++;
        if (q0.size() != 0) begin
            errors++;
            $display("FAIL %s pending=%0d first_cyc=%0d want 0 pending", name, q0.size(), q0[0].c);
            q0.delete();
        end
    endtask

    int b, k, m, p, q, r;

    initial begin
        RST = 1'b1; EXT_RN = 1'b1; SW_REQ = 1'b0;
        step(3);
        RST = 1'b0;
        b = cyc;
        push0(b, 4'b0000, 1'b0, 2'b01);
        push1(b, 1'b0, 1'b0, 2'b01);
        mon0_en = 1'b1; mon1_en = 1'b1;
        push_rel(b, 2'b01, 5);
        push1(b + 2, 1'b1, 1'b0, 2'b01);
        push1(b + 5, 1'b1, 1'b1, 2'b01);
        step(8);
        checks++;
        if (q1.size() != 0) begin
            errors++;
            $display("FAIL dom1_pending pending=%0d want 0", q1.size());
        end
        mon1_en = 1'b0;
        step_to(b + 34);
        drain0("seq_power_on");

        // SW_REQ pulse from RUN, then EXT_RN drop once RN=0011.
        SW_REQ = 1'b1; step(1); SW_REQ = 1'b0;
        k = cyc;
        push0(k, 4'b0000, 1'b0, 2'b11);
        push_rel(k, 2'b11, 2);
        step_to(k + 20);
        EXT_RN = 1'b0;
        m = cyc;
        push0(m + 3, 4'b0000, 1'b0, 2'b10);
        step_to(m + 6);
        SW_REQ = 1'b1; step(1); SW_REQ = 1'b0;
        step_to(m + 10);
        EXT_RN = 1'b1;
        push_rel(m + 12, 2'b10, 5);
        step_to(m + 12 + 34);
        drain0("seq_ext_rn");

        // SW_REQ from RUN, then again at hold count 10.
        SW_REQ = 1'b1; step(1); SW_REQ = 1'b0;
        p = cyc;
        push0(p, 4'b0000, 1'b0, 2'b11);
        step(10);
        SW_REQ = 1'b1; step(1); SW_REQ = 1'b0;
        push_rel(p + 11, 2'b11, 5);
        step_to(p + 11 + 34);
        drain0("seq_sw_restart");

        // RST and SW_REQ together while in RUN.
        RST = 1'b1; SW_REQ = 1'b1; step(1); RST = 1'b0; SW_REQ = 1'b0;
        q = cyc;
        push0(q, 4'b0000, 1'b0, 2'b01);
        push_rel(q, 2'b01, 5);
        step_to(q + 34);
        drain0("seq_rst_sw");

        // Random traffic; only the invariants are checked here.
        mon0_en = 1'b0;
        for (int i = 0; i < 400; i++) begin
            EXT_RN = ($urandom_range(0, 11) != 0);
            SW_REQ = ($urandom_range(0, 39) == 0);
            step(1);
        end
        EXT_RN = 1'b1; SW_REQ = 1'b0;
        step(3);

        RST = 1'b1; step(1); RST = 1'b0;
        r = cyc;
        mon0_en = 1'b1;
        push0(r, 4'b0000, 1'b0, 2'b01);
        push_rel(r, 2'b01, 5);
        step_to(r + 36);
        drain0("seq_after_random");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
